// File: rtl/mouse_axis_pkg.sv
// Shared types and arithmetic helpers for the mouse-to-analog-stick emulator.
package mouse_axis_pkg;

    typedef enum logic {
        PASS  = 1'b0,
        MOUSE = 1'b1
    } own_t;

    localparam int unsigned PS2_W  = 25;
    localparam int unsigned WORD_W = 16;

    // Limit one packet delta to +/-lim.
    function automatic int clamp_step(input int d, input int lim);
        int r;
        r = d;
        if (d > lim)
            r = lim;
        else if (d < -lim)
            r = -lim;
        return r;
    endfunction

    // Add delta to acc and saturate to the signed range of a w-bit axis.
    function automatic int sat_add(input int acc, input int delta, input int w);
        int sum;
        int hi;
        int lo;
        sum = acc + delta;
        hi  = (1 << (w - 1)) - 1;
        lo  = -(1 << (w - 1));
        if (sum > hi)
            sum = hi;
        else if (sum < lo)
            sum = lo;
        return sum;
    endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// Single-axis saturating accumulator: scaled/clamped packet delta plus decay toward zero.
module mouse_axis_acc
    import mouse_axis_pkg::*;
#(
    parameter int unsigned AXIS_W   = 8,
    parameter int          STEP_MAX = 10,
    parameter bit          NEGATE   = 1'b0
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     ev,
    input  logic                     tick,
    input  logic                     sign,
    input  logic [7:0]               mag,
    input  logic [1:0]               sens,
    output logic signed [AXIS_W-1:0] acc
);

    localparam logic signed [AXIS_W-1:0] ONE = AXIS_W'(1);

    logic signed [8:0] raw;
    logic signed [8:0] shifted;
    int                delta;

    assign raw     = $signed({sign, mag});
    assign shifted = raw >>> sens;

    // Scaled, clamped and optionally inverted step for this packet
    always_comb begin
        delta = clamp_step(int'(shifted), STEP_MAX);
        if (NEGATE)
            delta = -delta;
    end

    // Release clears; a packet wins over a decay tick in the same cycle
    always_ff @(posedge clk_sys) begin
        if (!reset_n || clr)
            acc <= '0;
        else if (ev)
            acc <= AXIS_W'(sat_add(int'(acc), delta, int'(AXIS_W)));
        else if (tick && acc != '0)
            acc <= acc[AXIS_W-1] ? acc + ONE : acc - ONE;
    end

endmodule

// File: rtl/mouse_axis_emu.sv
// Turns PS/2 mouse motion into an absolute analog stick on a selectable controller port.
module mouse_axis_emu
    import mouse_axis_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned AXIS_W    = 8,
    parameter int          STEP_MAX  = 10,
    parameter int unsigned DECAY_DIV = 65536,
    parameter bit          Y_INVERT  = 1'b0,
    localparam int unsigned SEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk_sys,
    input  logic                            reset_n,
    input  logic [PS2_W-1:0]                ps2_mouse,
    input  logic [SEL_W-1:0]                port_sel,
    input  logic                            spring,
    input  logic [1:0]                      sens,
    input  logic                            cpu_halt,
    input  logic [WORD_W*NUM_PORTS-1:0]     joy_in,
    input  logic [WORD_W*NUM_PORTS-1:0]     joya_in,
    output logic [WORD_W*NUM_PORTS-1:0]     joy_out,
    output logic [2*AXIS_W*NUM_PORTS-1:0]   joya_out,
    output logic                            mouse_active
);

    localparam int unsigned      DCNT_W    = $clog2(DECAY_DIV);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);

    own_t                     own_q;
    own_t                     own_d;
    logic                     old_stb;
    logic [SEL_W-1:0]         old_sel;
    logic [DCNT_W-1:0]        dcnt_q;
    logic [DCNT_W-1:0]        dcnt_d;
    logic                     ev;
    logic                     sel_joya_nz;
    logic                     drop;
    logic                     wrap;
    logic                     tick;
    logic signed [AXIS_W-1:0] mx;
    logic signed [AXIS_W-1:0] my;
    logic                     unused_bits;

    assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

    assign ev   = ps2_mouse[24] != old_stb;
    assign drop = sel_joya_nz | cpu_halt | (port_sel != old_sel);
    assign wrap = dcnt_q == DCNT_LAST;
    assign tick = (own_q == MOUSE) && spring && !drop && wrap && !ev;

    // The selected port's own analog stick is being moved
    always_comb begin
        sel_joya_nz = 1'b0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (port_sel == SEL_W'(p) && joya_in[WORD_W*p +: WORD_W] != '0)
                sel_joya_nz = 1'b1;
        end
    end

    // Ownership next-state and decay counter; release beats a packet
    always_comb begin
        own_d  = own_q;
        dcnt_d = '0;
        if (drop)
            own_d = MOUSE == own_q ? PASS : PASS;
        else if (ev)
            own_d = MOUSE;
        if (own_q == MOUSE && spring && !drop)
            dcnt_d = wrap ? '0 : dcnt_q + DCNT_ONE;
    end

    // State registers; strobe and selection history are tracked even in reset
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            own_q  <= PASS;
            dcnt_q <= '0;
        end else begin
            own_q  <= own_d;
            dcnt_q <= dcnt_d;
        end
        old_stb <= ps2_mouse[24];
        old_sel <= port_sel;
    end

    mouse_axis_acc #(
        .AXIS_W   (AXIS_W),
        .STEP_MAX (STEP_MAX),
        .NEGATE   (1'b0)
    ) u_acc_x (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr     (drop),
        .ev      (ev),
        .tick    (tick),
        .sign    (ps2_mouse[4]),
        .mag     (ps2_mouse[15:8]),
        .sens    (sens),
        .acc     (mx)
    );

    mouse_axis_acc #(
        .AXIS_W   (AXIS_W),
        .STEP_MAX (STEP_MAX),
        .NEGATE   (Y_INVERT)
    ) u_acc_y (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clr     (drop),
        .ev      (ev),
        .tick    (tick),
        .sign    (ps2_mouse[5]),
        .mag     (ps2_mouse[23:16]),
        .sens    (sens),
        .acc     (my)
    );

    // Pass-through mux with the mouse overlay on the owned port
    always_comb begin
        joy_out  = joy_in;
        joya_out = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            joya_out[2*AXIS_W*p +: AXIS_W]          = AXIS_W'($signed(joya_in[WORD_W*p +: 8]));
            joya_out[2*AXIS_W*p + AXIS_W +: AXIS_W] = AXIS_W'($signed(joya_in[WORD_W*p + 8 +: 8]));
            if (own_q == MOUSE && port_sel == SEL_W'(p)) begin
                joya_out[2*AXIS_W*p +: AXIS_W]          = mx;
                joya_out[2*AXIS_W*p + AXIS_W +: AXIS_W] = my;
                joy_out[WORD_W*p + 4 +: 2]              = ps2_mouse[1:0];
            end
        end
    end

    assign mouse_active = own_q == MOUSE;

endmodule

// File: tb/tb_mouse_axis_emu.sv
// Randomised bench with a behavioural model plus literal checkpoints for mouse_axis_emu.
module tb_mouse_axis_emu;

    localparam int DD   = 4;
    localparam int SMAX = 10;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [24:0] ps2_mouse;
    logic        port_sel;
    logic        spring;
    logic [1:0]  sens;
    logic        cpu_halt;
    logic [31:0] joy_in;
    logic [31:0] joya_in;
    logic [31:0] joy_out;
    logic [31:0] joya_out;
    logic        mouse_active;

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state
    bit   m_own = 1'b0;
    int   m_x   = 0;
    int   m_y   = 0;
    int   m_cnt = 0;
    bit   m_stb = 1'b0;
    logic m_sel = 1'b0;

    mouse_axis_emu #(
        .NUM_PORTS (2),
        .AXIS_W    (8),
        .STEP_MAX  (SMAX),
        .DECAY_DIV (DD),
        .Y_INVERT  (1'b1)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ps2_mouse    (ps2_mouse),
        .port_sel     (port_sel),
        .spring       (spring),
        .sens         (sens),
        .cpu_halt     (cpu_halt),
        .joy_in       (joy_in),
        .joya_in      (joya_in),
        .joy_out      (joy_out),
        .joya_out     (joya_out),
        .mouse_active (mouse_active)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Packet delta as a number: two's-complement value, floor-divided by 2^sh, limited.
    function automatic int step_of(input bit s, input logic [7:0] m, input int sh);
        int v;
        int d;
        v = s ? int'(m) - 256 : int'(m);
        d = 1 << sh;
        if (v >= 0)
            v = v / d;
        else
            v = -((-v + d - 1) / d);
        if (v > SMAX)  v = SMAX;
        if (v < -SMAX) v = -SMAX;
        return v;
    endfunction

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int toward0(input int v);
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return 0;
    endfunction

    // Model update on every edge, then compare all outputs just after it
    always @(posedge clk_sys) begin
        bit          ev;
        bit          drop;
        bit          was;
        logic [31:0] ej;
        logic [31:0] eja;
        if (!reset_n) begin
            m_own = 1'b0;
            m_x   = 0;
            m_y   = 0;
            m_cnt = 0;
        end else begin
            ev   = ps2_mouse[24] != m_stb;
            drop = cpu_halt || (port_sel != m_sel) || (joya_in[16*port_sel +: 16] != 16'h0);
            was  = m_own;
            if (drop) begin
                m_own = 1'b0;
                m_x   = 0;
                m_y   = 0;
                m_cnt = 0;
            end else begin
                if (ev) begin
                    m_x   = sat8(m_x + step_of(ps2_mouse[4], ps2_mouse[15:8], int'(sens)));
                    m_y   = sat8(m_y - step_of(ps2_mouse[5], ps2_mouse[23:16], int'(sens)));
                    m_own = 1'b1;
                end else if (was && spring && m_cnt == DD - 1) begin
                    m_x = toward0(m_x);
                    m_y = toward0(m_y);
                end
                m_cnt = (was && spring) ? (m_cnt + 1) % DD : 0;
            end
        end
        m_stb = ps2_mouse[24];
        m_sel = port_sel;
        #1;
        ej  = joy_in;
        eja = joya_in;
        if (m_own) begin
            if (port_sel == 1'b0) begin
                eja[15:0] = {8'(m_y), 8'(m_x)};
                ej[5:4]   = ps2_mouse[1:0];
            end else begin
                eja[31:16] = {8'(m_y), 8'(m_x)};
                ej[21:20]  = ps2_mouse[1:0];
            end
        end
        check("joy_out", 64'(joy_out), 64'(ej));
        check("joya_out", 64'(joya_out), 64'(eja));
        check("mouse_active", 64'(mouse_active), 64'(m_own));
    end

    task automatic send(input bit sx, input logic [7:0] dx, input bit sy, input logic [7:0] dy,
                        input logic [1:0] btn);
        @(negedge clk_sys);
        ps2_mouse[24]    = ~ps2_mouse[24];
        ps2_mouse[15:8]  = dx;
        ps2_mouse[4]     = sx;
        ps2_mouse[23:16] = dy;
        ps2_mouse[5]     = sy;
        ps2_mouse[1:0]   = btn;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    initial begin
        reset_n   = 1'b0;
        ps2_mouse = 25'($urandom);
        port_sel  = 1'b0;
        spring    = 1'b0;
        sens      = 2'd0;
        cpu_halt  = 1'b0;
        joy_in    = 32'hA5A5_5A5A;
        joya_in   = 32'h1234_0000;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        // reset state: everything passes through
        wait_edges(1);
        check("rst_active", 64'(mouse_active), 64'd0);
        check("rst_joya", 64'(joya_out), 64'h1234_0000);
        check("rst_joy", 64'(joy_out), 64'hA5A5_5A5A);

        // first packet takes port 0
        send(1'b0, 8'd5, 1'b0, 8'd0, 2'b10);
        wait_edges(1);
        check("first_x", 64'(joya_out[15:0]), 64'h0005);
        check("first_active", 64'(mouse_active), 64'd1);
        check("port1_pass", 64'(joya_out[31:16]), 64'h1234);
        check("buttons", 64'(joy_out[15:0]), 64'h5A6A);

        // step clamp and positive saturation, then a large negative step
        for (int i = 0; i < 20; i++)
            send(1'b0, 8'd100, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("sat_x", 64'(joya_out[15:0]), 64'h007F);
        send(1'b1, 8'h38, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("neg_step_x", 64'(joya_out[15:0]), 64'h0075);

        // own stick moved in the same cycle as a packet: release wins
        @(negedge clk_sys);
        joya_in[15:0]   = 16'h0001;
        ps2_mouse[24]   = ~ps2_mouse[24];
        ps2_mouse[15:8] = 8'd5;
        ps2_mouse[4]    = 1'b0;
        wait_edges(1);
        check("rel_active", 64'(mouse_active), 64'd0);
        check("rel_joya", 64'(joya_out[15:0]), 64'h0001);
        @(negedge clk_sys);
        joya_in[15:0] = 16'h0000;
        spring        = 1'b1;

        // spring decay, and a wrap coinciding with a packet
        send(1'b0, 8'd3, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("spr_3", 64'(joya_out[15:0]), 64'h0003);
        wait_edges(4);
        check("spr_2", 64'(joya_out[15:0]), 64'h0002);
        wait_edges(4);
        check("spr_1", 64'(joya_out[15:0]), 64'h0001);
        wait_edges(4);
        check("spr_0", 64'(joya_out[15:0]), 64'h0000);
        wait_edges(4);
        check("spr_hold0", 64'(joya_out[15:0]), 64'h0000);
        send(1'b0, 8'd5, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("spr_5", 64'(joya_out[15:0]), 64'h0005);
        wait_edges(2);
        send(1'b0, 8'd2, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("spr_wrap_ev", 64'(joya_out[15:0]), 64'h0007);
        wait_edges(4);
        check("spr_6", 64'(joya_out[15:0]), 64'h0006);

        // sensitivity shift with Y inverted
        @(negedge clk_sys);
        spring   = 1'b0;
        cpu_halt = 1'b1;
        @(negedge clk_sys);
        cpu_halt = 1'b0;
        sens     = 2'd2;
        send(1'b0, 8'd7, 1'b0, 8'd8, 2'b10);
        wait_edges(1);
        check("sens_xy", 64'(joya_out[15:0]), 64'hFE01);

        // port switch releases; mouse then drives port 1
        @(negedge clk_sys);
        sens     = 2'd0;
        port_sel = 1'b1;
        joya_in  = 32'h0;
        wait_edges(1);
        check("sel_rel", 64'(mouse_active), 64'd0);
        send(1'b0, 8'd9, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("p1_active", 64'(mouse_active), 64'd1);
        check("p1_joya", 64'(joya_out), 64'h0009_0000);
        @(negedge clk_sys);
        port_sel = 1'b0;
        wait_edges(1);
        check("p1_rel", 64'(mouse_active), 64'd0);
        check("p1_rel_joya", 64'(joya_out), 64'h0);

        // mid-stream reset with a strobe toggle inside it
        send(1'b0, 8'd3, 1'b0, 8'd0, 2'b00);
        wait_edges(1);
        check("pre_rst", 64'(mouse_active), 64'd1);
        @(negedge clk_sys);
        reset_n       = 1'b0;
        joya_in       = 32'h0304_0000;
        ps2_mouse[24] = ~ps2_mouse[24];
        wait_edges(1);
        check("mid_rst_active", 64'(mouse_active), 64'd0);
        check("mid_rst_joya", 64'(joya_out), 64'h0304_0000);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_edges(1);
        check("no_phantom1", 64'(mouse_active), 64'd0);
        wait_edges(1);
        check("no_phantom2", 64'(mouse_active), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_sys);
            reset_n  = ($urandom_range(499) != 0);
            cpu_halt = ($urandom_range(299) == 0);
            if ($urandom_range(199) == 0) port_sel = ~port_sel;
            if ($urandom_range(99) == 0) spring = ~spring;
            if ($urandom_range(7) == 0) sens = 2'($urandom_range(3));
            joy_in  = $urandom;
            joya_in = ($urandom_range(149) == 0) ? $urandom : 32'h0;
            if ($urandom_range(2) == 0) begin
                ps2_mouse[24]   = ~ps2_mouse[24];
                ps2_mouse[23:0] = 24'($urandom);
            end
        end

        repeat (3) @(negedge clk_sys);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
- Converts PS/2 mouse motion packets into absolute analog-stick positions for a selectable controller port. Generalises the single-port mouse-to-paddle logic of the 5200 top level.
- Sits between hps_io (ps2_mouse, joystick_N, joystick_analog_N) and the console core's JOYnX/JOYnY/JOYn inputs.
- Adds the following over the original logic:
  - N ports with runtime port selection.
  - Sensitivity shift.
  - Optional auto-recentre (spring) mode.
  - Optional Y inversion.

Parameters:
- NUM_PORTS, 2, number of controller ports passed through; 1..4.
- AXIS_W, 8, signed width of each analog axis.
- STEP_MAX, 10, maximum magnitude of one scaled packet delta.
- DECAY_DIV, 65536, clk_sys cycles per recentre step in spring mode; must be ≥2.
- Y_INVERT, 0, 1 = negate mouse Y before accumulation.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ps2_mouse  in  25  hps_io mouse word. [24] toggle strobe, [15:8] dx, [4] dx sign, [23:16] dy, [5] dy sign, [1:0] buttons.
- port_sel  in  $clog2(NUM_PORTS) (min 1)  port that the mouse drives.
- spring  in  1  1 = auto-recentre mode.
- sens  in  2  delta right-shift amount, 0..3.
- cpu_halt  in  1  forces release.
- joy_in  in  16*NUM_PORTS  digital joystick words, port p at [16p+15:16p].
- joya_in  in  16*NUM_PORTS  analog words, X=[7:0], Y=[15:8] per port.
- joy_out  out  16*NUM_PORTS  digital words to core.
- joya_out  out  2*AXIS_W*NUM_PORTS  analog words to core, X low, Y high per port.
- mouse_active  out  1  1 while the mouse owns the selected port.

Behaviour:
- State register `own` ∈ {PASS, MOUSE}. Signed accumulators mx, my, each AXIS_W bits. Register old_stb. Register old_sel. Decay counter dcnt of $clog2(DECAY_DIV) bits.
- Reset values: own=PASS; mx=my=0; dcnt=0; old_stb=ps2_mouse[24], captured during reset so no spurious event follows; old_sel=port_sel.
- Event: `ev` = (ps2_mouse[24] != old_stb). old_stb updates every cycle.
- Delta arithmetic:
  - dx9 = {sign, dx} as signed 9-bit. Apply arithmetic shift right by sens.
  - Clamp to [-STEP_MAX, +STEP_MAX].
  - Same for Y, negated if Y_INVERT.
- Accumulate:
  - On ev, nmx = mx + dx_clamped, computed at AXIS_W+1 bits.
  - Saturate to [-2^(AXIS_W-1), 2^(AXIS_W-1)-1]. Same for Y.
  - Result registered at the next edge: 1-cycle latency from the strobe-toggle edge.
- Transitions:
  - PASS→MOUSE on ev. The accumulate happens on that same edge.
  - MOUSE→PASS when any of: the selected port's joya_in is nonzero, cpu_halt=1, or port_sel != old_sel.
  - On MOUSE→PASS, mx=my=0.
  - Release has priority over ev in the same cycle: own=PASS and accumulators zero.
  - Release conditions are also evaluated in PASS: they hold the accumulators at 0 and keep own=PASS even if ev occurs.
- Spring mode (spring=1, own=MOUSE):
  - dcnt counts 0..DECAY_DIV-1 and wraps.
  - At wrap, each nonzero axis moves 1 toward 0, but only if ev=0 that cycle. If ev=1, the accumulate wins and the decay tick is lost.
  - When spring=0, dcnt is held at 0.
- Output mux (combinational from registered state):
  - Non-selected ports, or own=PASS: joy_out = joy_in and joya_out = joya_in, sign-extended or truncated to AXIS_W.
  - Selected port with own=MOUSE: joya_out = {my, mx}, and joy_out bits [5:4] are replaced by ps2_mouse[1:0].
- mouse_active = (own==MOUSE).
- Mid-operation reset returns every register to its reset value on the next edge. Outputs are pass-through in the cycle after reset_n goes low.

Decomposition:
- Package mouse_axis_pkg:
  - own_t enum {PASS, MOUSE}.
  - function sat_add(acc, delta, W).
  - function clamp_step(d, max).
- One sub-module, mouse_axis_acc: a single-axis saturating accumulator with step clamp and decay-toward-zero. Instantiated twice (X, Y).

Test Plan:
- Reset, port_sel=0, sens=0. Toggle strobe with dx=+5 → mouse_active=1 and port 0 X=5 one cycle after the toggle; port 1 stays pass-through.
- 20 packets of dx=+100, sens=0 → each step clamps to +10 and X saturates at 127. Then dx=-200 (sign=1, 0x38) → X=117.
- In MOUSE, set joya_in port 0 = 0x0001 in the same cycle as a strobe toggle → next cycle own=PASS, mx=my=0, joya_out passes 0x0001.
- spring=1, DECAY_DIV=4, X=3 → X reads 2, 1, 0 at successive 4-cycle wraps, then stays 0. A wrap coinciding with ev applies only the delta.
- sens=2, dx=+7, Y_INVERT=1 with dy=+8 → X=+1, Y=-2.
- In MOUSE on port 1, change port_sel to 0 → release to PASS and accumulators 0. Then pulse reset_n low mid-stream → all outputs pass-through and no phantom event after reset.
